// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data has fixed priority, fetch gets a bounded-starvation
// override, and the data side can lock the memory for atomic sequences with a timeout.
module mem_arbiter #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 16,
   parameter int STARVE_MAX = 3,
   parameter int LOCK_MAX   = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic              dm_lock,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_valid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              lock_err
);

   localparam int WAIT_W = $clog2(STARVE_MAX + 1);
   localparam int LCNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

   typedef enum logic [1:0] {WIN_NONE, WIN_IF, WIN_DM} win_t;

   logic              if_gnt_reg, if_gnt_next;
   logic              dm_gnt_reg, dm_gnt_next;
   logic              mem_en_reg, mem_en_next;
   logic              mem_we_reg, mem_we_next;
   logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
   logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
   logic              pend_if_reg, pend_if_next;
   logic              pend_dm_reg, pend_dm_next;
   logic [WAIT_W-1:0] if_wait_reg, if_wait_next;
   logic              lock_active_reg, lock_active_next;
   logic [LCNT_W-1:0] lock_cnt_reg, lock_cnt_next;
   logic              lock_err_reg, lock_err_next;

   logic if_elig, dm_elig, starved, lock_timeout;
   win_t winner;

   always_comb begin
      if_elig      = if_req && !if_gnt_reg && !lock_active_reg;
      dm_elig      = dm_req && !dm_gnt_reg;
      starved      = if_elig && (if_wait_reg == WAIT_W'(STARVE_MAX));
      lock_timeout = lock_active_reg && (lock_cnt_reg == LCNT_W'(LOCK_MAX - 1));

      winner = WIN_NONE;
      if (dm_elig && !starved)
         winner = WIN_DM;
      else if (if_elig)
         winner = WIN_IF;

      if_gnt_next    = (winner == WIN_IF);
      dm_gnt_next    = (winner == WIN_DM);
      mem_en_next    = (winner != WIN_NONE);
      mem_we_next    = (winner == WIN_DM) && dm_we;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;
      if (winner == WIN_IF) begin
         mem_addr_next = if_addr;
      end else if (winner == WIN_DM) begin
         mem_addr_next  = dm_addr;
         mem_wdata_next = dm_wdata;
      end

      // A grant in this cycle means the memory sees the command now; data returns next cycle.
      pend_if_next = if_gnt_reg;
      pend_dm_next = dm_gnt_reg && !mem_we_reg;

      // Fetch counts every edge it is waiting and loses, including while locked out.
      if_wait_next = if_wait_reg;
      if ((winner == WIN_IF) || !if_req)
         if_wait_next = '0;
      else if (!if_gnt_reg && (if_wait_reg != WAIT_W'(STARVE_MAX)))
         if_wait_next = if_wait_reg + WAIT_W'(1);

      lock_active_next = lock_active_reg;
      lock_cnt_next    = lock_active_reg ? lock_cnt_reg + LCNT_W'(1) : '0;
      lock_err_next    = lock_err_reg;
      if (lock_timeout) begin
         lock_active_next = 1'b0;
         lock_cnt_next    = '0;
         lock_err_next    = 1'b1;
      end else if (winner == WIN_DM) begin
         lock_active_next = dm_lock;
         if (!dm_lock)
            lock_cnt_next = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         if_gnt_reg      <= 1'b0;
         dm_gnt_reg      <= 1'b0;
         mem_en_reg      <= 1'b0;
         mem_we_reg      <= 1'b0;
         mem_addr_reg    <= '0;
         mem_wdata_reg   <= '0;
         pend_if_reg     <= 1'b0;
         pend_dm_reg     <= 1'b0;
         if_wait_reg     <= '0;
         lock_active_reg <= 1'b0;
         lock_cnt_reg    <= '0;
         lock_err_reg    <= 1'b0;
      end else begin
         if_gnt_reg      <= if_gnt_next;
         dm_gnt_reg      <= dm_gnt_next;
         mem_en_reg      <= mem_en_next;
         mem_we_reg      <= mem_we_next;
         mem_addr_reg    <= mem_addr_next;
         mem_wdata_reg   <= mem_wdata_next;
         pend_if_reg     <= pend_if_next;
         pend_dm_reg     <= pend_dm_next;
         if_wait_reg     <= if_wait_next;
         lock_active_reg <= lock_active_next;
         lock_cnt_reg    <= lock_cnt_next;
         lock_err_reg    <= lock_err_next;
      end
   end

   assign if_gnt    = if_gnt_reg;
   assign dm_gnt    = dm_gnt_reg;
   assign mem_en    = mem_en_reg;
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign if_valid  = pend_if_reg;
   assign dm_valid  = pend_dm_reg;
   assign if_rdata  = mem_rdata;
   assign dm_rdata  = mem_rdata;
   assign lock_err  = lock_err_reg;

endmodule
